// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer.
// A Moore FSM walks each instruction through FETCH/DECODE/execute/memory/
// write-back. One ALU and one unified memory port are shared between
// these steps. The opcode is captured in DECODE so that later steps do not
// depend on the instruction register staying stable.
//
// Memory handshake: o_mem_req is held high, with o_memWrite and o_iorD
// stable, for as long as the FSM sits in FETCH, MRD or MWR. A transfer
// completes in exactly one cycle: the cycle in which o_mem_req and
// i_mem_ready are both high. That cycle may be the first cycle of the
// request (zero wait). i_mem_ready has no effect while o_mem_req is low.
module mips_multicycle_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opCode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_memWrite,
  output logic       o_iorD,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic [1:0] o_pcSrc,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic       o_extOp,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_memToReg,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  // Opcode values of the supported instructions
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_FETCH = 4'd1,
    S_DEC   = 4'd2,
    S_EXR   = 4'd3,
    S_WBR   = 4'd4,
    S_EXI   = 4'd5,
    S_WBI   = 4'd6,
    S_MADDR = 4'd7,
    S_MRD   = 4'd8,
    S_MWB   = 4'd9,
    S_MWR   = 4'd10,
    S_BR    = 4'd11,
    S_JMP   = 4'd12,
    S_HALT  = 4'd13
  } state_t;

  state_t     state_q;
  state_t     state_d;
  state_t     dispatch;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       imm_signed;
  logic       is_bne;

  // Pick the first execute state from the live opcode while in DECODE
  always_comb begin
    dispatch = S_HALT;
    case (i_opCode)
      OP_RTYPE: dispatch = S_EXR;
      OP_ADDI,
      OP_ADDIU,
      OP_SLTI,
      OP_ANDI,
      OP_ORI,
      OP_XORI:  dispatch = S_EXI;
      OP_LW,
      OP_SW:    dispatch = S_MADDR;
      OP_BEQ,
      OP_BNE:   dispatch = S_BR;
      OP_J:     dispatch = S_JMP;
      default:  dispatch = S_HALT;
    endcase
  end

  // Properties of the latched opcode used after DECODE
  assign imm_signed = (op_q == OP_ADDI) || (op_q == OP_SLTI);
  assign is_bne     = (op_q == OP_BNE);

  // State register; reset aborts any instruction immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the opcode once, in DECODE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q <= 6'b000000;
    end else if (state_q == S_DEC) begin
      op_q <= i_opCode;
    end
  end

  // Sticky illegal-opcode flag, set on the way into HALT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_q <= 1'b0;
    end else if ((state_q == S_DEC) && (dispatch == S_HALT)) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: state_d = i_mem_ready ? S_DEC : S_FETCH;
      S_DEC:   state_d = dispatch;
      S_EXR:   state_d = S_WBR;
      S_WBR:   state_d = S_FETCH;
      S_EXI:   state_d = S_WBI;
      S_WBI:   state_d = S_FETCH;
      S_MADDR: state_d = (op_q == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   state_d = i_mem_ready ? S_MWB : S_MRD;
      S_MWB:   state_d = S_FETCH;
      S_MWR:   state_d = i_mem_ready ? S_FETCH : S_MWR;
      S_BR:    state_d = S_FETCH;
      S_JMP:   state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Per-state datapath controls; only FETCH and BR look at inputs
  always_comb begin
    o_mem_req  = 1'b0;
    o_memWrite = 1'b0;
    o_iorD     = 1'b0;
    o_irWrite  = 1'b0;
    o_pcWrite  = 1'b0;
    o_pcSrc    = 2'b00;
    o_aluSrcA  = 1'b0;
    o_aluSrcB  = 2'b00;
    o_aluOp    = 2'b00;
    o_extOp    = 1'b0;
    o_regDst   = 1'b0;
    o_regWrite = 1'b0;
    o_memToReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read
        o_mem_req = 1'b1;
        o_aluSrcB = 2'b01;
        o_irWrite = i_mem_ready;
        o_pcWrite = i_mem_ready;
      end
      S_DEC: begin
        // Branch target PC + (sext(imm) << 2) precomputed speculatively
        o_aluSrcB = 2'b11;
        o_extOp   = 1'b1;
      end
      S_EXR: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = 2'b10;
      end
      S_WBR: begin
        o_regDst   = 1'b1;
        o_regWrite = 1'b1;
      end
      S_EXI: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
        o_aluOp   = 2'b11;
        o_extOp   = imm_signed;
      end
      S_WBI: begin
        // Extension kept steady through write-back
        o_regWrite = 1'b1;
        o_extOp    = imm_signed;
      end
      S_MADDR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
        o_extOp   = 1'b1;
      end
      S_MRD: begin
        o_mem_req = 1'b1;
        o_iorD    = 1'b1;
      end
      S_MWB: begin
        o_regWrite = 1'b1;
        o_memToReg = 1'b1;
      end
      S_MWR: begin
        o_mem_req  = 1'b1;
        o_memWrite = 1'b1;
        o_iorD     = 1'b1;
      end
      S_BR: begin
        // Compare by subtraction; take branch on zero (BEQ) or non-zero (BNE)
        o_aluSrcA = 1'b1;
        o_aluOp   = 2'b01;
        o_pcSrc   = 2'b01;
        o_pcWrite = is_bne ? ~i_zero : i_zero;
      end
      S_JMP: begin
        o_pcWrite = 1'b1;
        o_pcSrc   = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign o_illegal = illegal_q;
  assign o_state   = state_q;

endmodule
